// File: rtl/imem_loader.sv
// imem_loader: run-time loader that assembles a host byte stream into 32-bit
// instruction words and writes them to instruction memory from word 0 upward,
// holding the CPU in reset until the image is complete.
//   clk, reset (async, active-low)
//   start, len_words, abort          : load control
//   in_valid, in_byte, in_ready      : host byte stream, MSB of each word first
//   im_we, im_addr, im_wdata         : instruction memory write port
//   busy, done, err, cpu_hold        : status
//   checksum                         : XOR of the words written by this load
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len_words,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    output logic [31:0]   checksum
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    state_t      state, state_nx;
    logic [AW:0] len;
    logic [1:0]  bcnt;
    logic        go, bad, last, take;
    assign in_ready = state == RECV;
    assign busy     = state == RECV || state == WRITE;
    assign done     = state == DONE;
    assign cpu_hold = state != DONE;
    // abort in the WRITE cycle suppresses the write
    assign im_we    = state == WRITE && !abort;
    always_comb begin
        go       = start && !abort && (state == IDLE || state == DONE);
        bad      = len_words == '0 || len_words > (AW+1)'(DEPTH);
        last     = {1'b0, im_addr} == len - 1'b1;
        take     = state == RECV && in_valid;
        state_nx = state;
        if (go && !bad)
            state_nx = RECV;
        else if (abort && busy)
            state_nx = IDLE;
        else if (take && bcnt == 2'd3)
            state_nx = WRITE;
        else if (state == WRITE)
            state_nx = last ? DONE : RECV;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            len      <= '0;
            bcnt     <= '0;
            im_addr  <= '0;
            im_wdata <= '0;
            err      <= 1'b0;
            checksum <= '0;
        end else begin
            state <= state_nx;
            if (go && bad)
                err <= 1'b1;
            if (go && !bad) begin
                len      <= len_words;
                bcnt     <= '0;
                im_addr  <= '0;
                err      <= 1'b0;
                checksum <= '0;
            end
            if (take) begin
                im_wdata <= {im_wdata[23:0], in_byte};
                bcnt     <= bcnt + 2'd1;
            end
            if (im_we) begin
                checksum <= checksum ^ im_wdata;
                if (!last)
                    im_addr <= im_addr + 1'b1;
            end
        end
    end
endmodule
